reg_file_mp: RTL and testbench

Parametrised multi-port successor to the single-write, dual-read RV32I register file.
- Configurable read-port count, write-port count, data width and depth.
- Adds a per-register busy scoreboard so the pipeline can issue past in-flight writes; x0 stays hardwired to zero.
- Sits in the decode stage and feeds operands to execute; write-back ports come from the retire stages.

---
 rtl/riscv_32i_defs_pkg.sv | 16 +
 rtl/reg_scoreboard.sv | 62 ++++++
 rtl/reg_file_mp.sv | 118 +++++++++++
 tb/tb_reg_file_mp.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_32i_defs_pkg.sv
// -----------------------------------------------------------------------------
// riscv_32i_defs_pkg
// Shared RV32I register-file definitions: default data width, register count
// and index width, plus the word / register-index typedefs used by the decode
// stage. The multi-port register file takes its parameter defaults from here.
// -----------------------------------------------------------------------------
package riscv_32i_defs_pkg;

  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = $clog2(NUM_REGS);

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       word_t;

endpackage : riscv_32i_defs_pkg

// File: rtl/reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
// One busy flop per architectural register. A register is set busy when an
// instruction with that destination issues (alloc) and cleared when any write
// port retires a value into it. A same-cycle alloc beats a clear, because the
// alloc belongs to the newer producer. Register 0 is never busy.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset, clears every busy bit
//   alloc_en   mark alloc_reg busy at the next edge
//   alloc_reg  register index to mark busy
//   wr_en      per write-port enable
//   wr_reg     per write-port register index
//   busy       registered busy vector, bit r belongs to register r
// -----------------------------------------------------------------------------
module reg_scoreboard #(
  parameter int NUM_REGS = riscv_32i_defs_pkg::NUM_REGS,
  parameter int NUM_WR   = 2,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           alloc_en,
  input  logic [ADDR_W-1:0]              alloc_reg,
  input  logic [NUM_WR-1:0]              wr_en,
  input  logic [NUM_WR-1:0][ADDR_W-1:0]  wr_reg,
  output logic [NUM_REGS-1:0]            busy
);

  import riscv_32i_defs_pkg::*;

  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] busy_nxt_s;

  // Next busy state: set on alloc, otherwise clear on any effective write.
  always_comb begin
    busy_nxt_s = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      logic clr_s;
      logic set_s;
      clr_s = 1'b0;
      for (int w = 0; w < NUM_WR; w++) begin
        clr_s = clr_s | (wr_en[w] & (wr_reg[w] == ADDR_W'(r)));
      end
      set_s         = alloc_en & (alloc_reg == ADDR_W'(r));
      busy_nxt_s[r] = set_s | (busy_r[r] & ~clr_s);
    end
  end

  // Busy flop array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= '0;
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  assign busy = busy_r;

endmodule : reg_scoreboard

// File: rtl/reg_file_mp.sv
// -----------------------------------------------------------------------------
// reg_file_mp
// Parametrised multi-port register file with a per-register busy scoreboard.
// Reads are combinational; writes land on the rising edge. Register 0 always
// reads as zero, is never busy, and ignores writes and allocs. When several
// write ports target the same register in one cycle the highest-index port
// wins.
//
// Build option: define WR_BYPASS_EN to forward same-cycle write data to the
// read ports (highest-index matching write port wins). In that case the
// forwarded read reports busy only if this cycle's alloc targets the same
// register. Without the macro, reads see stored contents and stored busy only.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (data and busy clear to 0)
//   rd_reg     NUM_RD read indices
//   rd_data    NUM_RD read data words
//   rd_busy    NUM_RD busy flags of the addressed registers
//   wr_en      NUM_WR write enables
//   wr_reg     NUM_WR write indices
//   wr_data    NUM_WR write data words
//   alloc_en   mark alloc_reg busy at the next edge
//   alloc_reg  register index to mark busy
// -----------------------------------------------------------------------------
module reg_file_mp #(
  parameter int XLEN     = riscv_32i_defs_pkg::XLEN,
  parameter int NUM_REGS = riscv_32i_defs_pkg::NUM_REGS,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_reg,
  output logic [NUM_RD-1:0][XLEN-1:0]    rd_data,
  output logic [NUM_RD-1:0]              rd_busy,
  input  logic [NUM_WR-1:0]              wr_en,
  input  logic [NUM_WR-1:0][ADDR_W-1:0]  wr_reg,
  input  logic [NUM_WR-1:0][XLEN-1:0]    wr_data,
  input  logic                           alloc_en,
  input  logic [ADDR_W-1:0]              alloc_reg
);

  import riscv_32i_defs_pkg::*;

  logic [XLEN-1:0]             regs_r [NUM_REGS];
  logic [NUM_WR-1:0]           wr_live_s;
  logic                        alloc_live_s;
  logic [NUM_REGS-1:0]         busy_s;
  logic [NUM_RD-1:0][XLEN-1:0] rd_data_s;
  logic [NUM_RD-1:0]           rd_busy_s;

  // A write or alloc aimed at register 0 is dropped before it reaches state.
  always_comb begin
    wr_live_s = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      wr_live_s[w] = wr_en[w] & (wr_reg[w] != {ADDR_W{1'b0}});
    end
    alloc_live_s = alloc_en & (alloc_reg != {ADDR_W{1'b0}});
  end

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_WR   (NUM_WR),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .alloc_en  (alloc_live_s),
    .alloc_reg (alloc_reg),
    .wr_en     (wr_live_s),
    .wr_reg    (wr_reg),
    .busy      (busy_s)
  );

  // Data array; ports are applied in ascending order so the highest index wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_r[r] <= {XLEN{1'b0}};
      end
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_live_s[w]) begin
          regs_r[wr_reg[w]] <= wr_data[w];
        end
      end
    end
  end

  // Combinational read ports, with optional same-cycle write forwarding.
  always_comb begin
    rd_data_s = '0;
    rd_busy_s = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (rst_n && (rd_reg[p] != {ADDR_W{1'b0}})) begin
        rd_data_s[p] = regs_r[rd_reg[p]];
        rd_busy_s[p] = busy_s[rd_reg[p]];
`ifdef WR_BYPASS_EN
        for (int w = 0; w < NUM_WR; w++) begin
          logic hit_s;
          hit_s        = wr_live_s[w] & (wr_reg[w] == rd_reg[p]);
          rd_data_s[p] = hit_s ? wr_data[w] : rd_data_s[p];
          rd_busy_s[p] = hit_s ? (alloc_live_s & (alloc_reg == rd_reg[p])) : rd_busy_s[p];
        end
`endif
      end else begin
        rd_data_s[p] = {XLEN{1'b0}};
        rd_busy_s[p] = 1'b0;
      end
    end
  end

  assign rd_data = rd_data_s;
  assign rd_busy = rd_busy_s;

endmodule : reg_file_mp

// File: tb/tb_reg_file_mp.sv
// -----------------------------------------------------------------------------
// tb_reg_file_mp
// Self-checking bench for reg_file_mp (default parameters). Directed scenarios
// use literal expectations; the random phase compares against an array-based
// architectural model. Honours WR_BYPASS_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_reg_file_mp;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int NUM_RD   = 2;
  localparam int NUM_WR   = 2;
  localparam int ADDR_W   = 5;

  logic                          clk;
  logic                          rst_n;
  logic [NUM_RD-1:0][ADDR_W-1:0] rd_reg;
  logic [NUM_RD-1:0][XLEN-1:0]   rd_data;
  logic [NUM_RD-1:0]             rd_busy;
  logic [NUM_WR-1:0]             wr_en;
  logic [NUM_WR-1:0][ADDR_W-1:0] wr_reg;
  logic [NUM_WR-1:0][XLEN-1:0]   wr_data;
  logic                          alloc_en;
  logic [ADDR_W-1:0]             alloc_reg;

  int n_cmp  = 0;
  int n_fail = 0;

  // Architectural model
  logic [XLEN-1:0] m_mem  [NUM_REGS];
  logic            m_busy [NUM_REGS];

  reg_file_mp #(
    .XLEN(XLEN), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rd_reg(rd_reg), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_reg(alloc_reg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_clear();
    for (int r = 0; r < NUM_REGS; r++) begin
      m_mem[r]  = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  // Wait for the next rising edge, apply the architectural update, step off the edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && wr_reg[w] != 0) begin
          m_mem[wr_reg[w]]  = wr_data[w];
          m_busy[wr_reg[w]] = 1'b0;
        end
      end
      if (alloc_en && alloc_reg != 0) m_busy[alloc_reg] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    wr_en = '0; wr_reg = '0; wr_data = '0; alloc_en = 1'b0; alloc_reg = '0;
  endtask

  function automatic logic [XLEN-1:0] exp_data(input logic [ADDR_W-1:0] a);
    logic [XLEN-1:0] d;
    if (!rst_n || a == 0) return '0;
    d = m_mem[a];
`ifdef WR_BYPASS_EN
    for (int w = 0; w < NUM_WR; w++)
      if (wr_en[w] && wr_reg[w] == a) d = wr_data[w];
`endif
    return d;
  endfunction

  function automatic logic exp_busy(input logic [ADDR_W-1:0] a);
    logic b;
    if (!rst_n || a == 0) return 1'b0;
    b = m_busy[a];
`ifdef WR_BYPASS_EN
    for (int w = 0; w < NUM_WR; w++)
      if (wr_en[w] && wr_reg[w] == a) b = alloc_en && (alloc_reg == a);
`endif
    return b;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; idle(); rd_reg = '0; rd_reg[0] = 5'd5; rd_reg[1] = 5'd7;
    model_clear();
    #3;
    n_cmp++;
    if (rd_data !== '0 || rd_busy !== '0) begin
      n_fail++; $display("FAIL reset_initial: data=%h busy=%b expected 0/0", rd_data, rd_busy);
    end
    tick(); rst_n = 1'b1; tick();
    wr_en = 2'b01; wr_reg[0] = 5'd5; wr_data[0] = 32'hDEADBEEF;
    alloc_en = 1'b1; alloc_reg = 5'd5;
    tick(); idle(); #1;
    n_cmp++;
    if (rd_data[0] !== 32'hDEADBEEF || rd_busy[0] !== 1'b1) begin
      n_fail++; $display("FAIL reset_prewrite: data=%h busy=%b expected deadbeef/1", rd_data[0], rd_busy[0]);
    end
    #2; rst_n = 1'b0; #1;
    model_clear();
    n_cmp++;
    if (rd_data[0] !== '0 || rd_busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL reset_async: data=%h busy=%b expected 0/0", rd_data[0], rd_busy[0]);
    end
    // A write presented while reset is held must be discarded.
    wr_en = 2'b01; wr_reg[0] = 5'd5; wr_data[0] = 32'h0BAD0BAD;
    tick(); idle(); rst_n = 1'b1; #1;
    n_cmp++;
    if (rd_data[0] !== '0 || rd_busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL reset_discard: data=%h busy=%b expected 0/0", rd_data[0], rd_busy[0]);
    end
  endtask

  task automatic test_dual_write();
    idle(); wr_en = 2'b11; wr_reg[0] = 5'd7; wr_reg[1] = 5'd7;
    wr_data[0] = 32'h1111; wr_data[1] = 32'h2222;
    tick(); idle(); rd_reg[0] = 5'd7; rd_reg[1] = 5'd7; #1;
    n_cmp++;
    if (rd_data[0] !== 32'h2222 || rd_data[1] !== 32'h2222) begin
      n_fail++; $display("FAIL dual_write: got %h/%h expected 00002222", rd_data[0], rd_data[1]);
    end
    // Port 0 write only: must still land when port 1 is idle.
    wr_en = 2'b01; wr_reg[0] = 5'd7; wr_data[0] = 32'h3333;
    tick(); idle(); #1;
    n_cmp++;
    if (rd_data[1] !== 32'h3333) begin
      n_fail++; $display("FAIL port0_write: got %h expected 00003333", rd_data[1]);
    end
  endtask

  task automatic test_x0();
    idle(); wr_en = 2'b11; wr_reg[0] = 5'd0; wr_reg[1] = 5'd0;
    wr_data[0] = 32'hFFFFFFFF; wr_data[1] = 32'hFFFFFFFF;
    alloc_en = 1'b1; alloc_reg = 5'd0; rd_reg[0] = 5'd0; rd_reg[1] = 5'd0; #1;
    n_cmp++;
    if (rd_data !== '0 || rd_busy !== '0) begin
      n_fail++; $display("FAIL x0_same_cycle: data=%h busy=%b expected 0/0", rd_data, rd_busy);
    end
    tick(); idle(); #1;
    n_cmp++;
    if (rd_data !== '0 || rd_busy !== '0) begin
      n_fail++; $display("FAIL x0_after: data=%h busy=%b expected 0/0", rd_data, rd_busy);
    end
  endtask

  task automatic test_scoreboard();
    idle(); rd_reg[0] = 5'd3; rd_reg[1] = 5'd4;
    alloc_en = 1'b1; alloc_reg = 5'd3;
    tick(); idle(); #1;
    n_cmp++;
    if (rd_busy[0] !== 1'b1 || rd_busy[1] !== 1'b0) begin
      n_fail++; $display("FAIL sb_alloc: busy=%b expected 01", rd_busy);
    end
    alloc_en = 1'b1; alloc_reg = 5'd3;
    tick(); idle(); #1;
    n_cmp++;
    if (rd_busy[0] !== 1'b1) begin
      n_fail++; $display("FAIL sb_realloc: busy=%b expected 1", rd_busy[0]);
    end
    wr_en = 2'b10; wr_reg[1] = 5'd3; wr_data[1] = 32'hA5;
    tick(); idle(); #1;
    n_cmp++;
    if (rd_busy[0] !== 1'b0 || rd_data[0] !== 32'hA5) begin
      n_fail++; $display("FAIL sb_clear: busy=%b data=%h expected 0/000000a5", rd_busy[0], rd_data[0]);
    end
    wr_en = 2'b01; wr_reg[0] = 5'd3; wr_data[0] = 32'h5A;
    alloc_en = 1'b1; alloc_reg = 5'd3;
    tick(); idle(); #1;
    n_cmp++;
    if (rd_busy[0] !== 1'b1 || rd_data[0] !== 32'h5A) begin
      n_fail++; $display("FAIL sb_alloc_and_write: busy=%b data=%h expected 1/0000005a", rd_busy[0], rd_data[0]);
    end
  endtask

  task automatic test_bypass();
    logic [XLEN-1:0] exp_same;
    idle(); wr_en = 2'b01; wr_reg[0] = 5'd9; wr_data[0] = 32'h55;
    tick(); idle();
    rd_reg[0] = 5'd9; rd_reg[1] = 5'd9;
    wr_en = 2'b10; wr_reg[1] = 5'd9; wr_data[1] = 32'h1234; #1;
`ifdef WR_BYPASS_EN
    exp_same = 32'h1234;
`else
    exp_same = 32'h55;
`endif
    n_cmp++;
    if (rd_data[0] !== exp_same || rd_busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL bypass_same_cycle: data=%h busy=%b expected %h/0", rd_data[0], rd_busy[0], exp_same);
    end
    tick(); idle(); #1;
    n_cmp++;
    if (rd_data[1] !== 32'h1234) begin
      n_fail++; $display("FAIL bypass_next_cycle: data=%h expected 00001234", rd_data[1]);
    end
  endtask

  task automatic test_random();
    logic [XLEN-1:0] ed;
    logic            eb;
    for (int t = 0; t < 1000; t++) begin
      for (int w = 0; w < NUM_WR; w++) begin
        wr_en[w]   = ($urandom_range(0, 2) != 0);
        wr_reg[w]  = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(0, NUM_REGS-1))
                                                 : ADDR_W'($urandom_range(0, 7));
        wr_data[w] = $urandom;
      end
      alloc_en  = ($urandom_range(0, 1) == 1);
      alloc_reg = ADDR_W'($urandom_range(0, 7));
      for (int p = 0; p < NUM_RD; p++) begin
        rd_reg[p] = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(0, NUM_REGS-1))
                                                : ADDR_W'($urandom_range(0, 7));
      end
      #1;
      for (int p = 0; p < NUM_RD; p++) begin
        ed = exp_data(rd_reg[p]);
        eb = exp_busy(rd_reg[p]);
        n_cmp++;
        if (rd_data[p] !== ed || rd_busy[p] !== eb) begin
          n_fail++;
          $display("FAIL random t=%0d port=%0d reg=%0d: data=%h busy=%b expected %h/%b",
                   t, p, rd_reg[p], rd_data[p], rd_busy[p], ed, eb);
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_dual_write();
    test_x0();
    test_scoreboard();
    test_bypass();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_reg_file_mp
